walker_checker: RTL and testbench

WALKER_CHECKER -- requirements
Module: walker_checker

---
 rtl/walker_pkg.sv | 12 +
 rtl/onehot_decode.sv | 19 +
 rtl/walker_checker.sv | 131 +++++++++++++
 tb/tb_walker_checker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/walker_pkg.sv
// Shared constants and FSM state encoding for the LED walker checker.
package walker_pkg;
   localparam int LED_W = 7;
   localparam int POS_W = 3;
   localparam logic [POS_W-1:0] POS_MAX = 3'd6;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } state_t;
endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot check and index decode of the observed LED bus.
module onehot_decode
   import walker_pkg::*;
(
   input  logic [LED_W-1:0] led,
   output logic             valid,
   output logic [POS_W-1:0] idx
);

   always_comb begin
      // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
      valid = (led != '0) && ((led & (led - LED_W'(1))) == '0);
      idx   = '0;
      for (int i = 0; i < LED_W; i++) begin
         if (led[i]) idx = POS_W'(i);
      end
   end

endmodule

// File: rtl/walker_checker.sv
// Tracks a bouncing single-LED walker, flags illegal samples and counts round trips.
module walker_checker
   import walker_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_strobe,
   input  logic [LED_W-1:0] i_led,
   input  logic             i_clear,
   output logic [POS_W-1:0] o_pos,
   output logic             o_dir,
   output logic             o_locked,
   output logic             o_error,
   output logic [CNT_W-1:0] o_err_count,
   output logic [CNT_W-1:0] o_sweeps
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t           state, state_n;
   logic [POS_W-1:0] pos_n, exp_pos, q;
   logic             dir_n, exp_dir, err_n, q_vld;
   logic [CNT_W-1:0] err_cnt_n, sweeps_n;

   onehot_decode u_decode (
      .led   (i_led),
      .valid (q_vld),
      .idx   (q)
   );

   // Next position of a legal walk, reflecting at both ends.
   always_comb begin
      exp_pos = o_pos;
      exp_dir = o_dir;
      if (!o_dir) begin
         if (o_pos < POS_MAX) begin
            exp_pos = o_pos + 3'd1;
         end else begin
            exp_pos = POS_MAX - 3'd1;
            exp_dir = 1'b1;
         end
      end else if (o_pos != '0) begin
         exp_pos = o_pos - 3'd1;
      end else begin
         exp_pos = 3'd1;
         exp_dir = 1'b0;
      end
   end

   always_comb begin
      state_n   = state;
      pos_n     = o_pos;
      dir_n     = o_dir;
      err_n     = 1'b0;
      err_cnt_n = o_err_count;
      sweeps_n  = o_sweeps;
      if (i_clear) begin
         state_n   = SEARCH;
         err_cnt_n = '0;
         sweeps_n  = '0;
      end else if (i_strobe) begin
         unique case (state)
            SEARCH: begin
               if (q_vld) begin
                  pos_n   = q;
                  state_n = ACQUIRE;
               end
            end
            ACQUIRE: begin
               // p+1 / p-1 wrap to 7 at the ends, which no valid q can match.
               if (q_vld && q == o_pos) begin
                  state_n = ACQUIRE;
               end else if (q_vld && q == o_pos + 3'd1) begin
                  pos_n   = q;
                  dir_n   = 1'b0;
                  state_n = TRACK;
               end else if (q_vld && q == o_pos - 3'd1) begin
                  pos_n   = q;
                  dir_n   = 1'b1;
                  state_n = TRACK;
               end else begin
                  err_n = 1'b1;
               end
            end
            TRACK: begin
               if (q_vld && q == o_pos) begin
                  state_n = TRACK;
               end else if (q_vld && q == exp_pos) begin
                  pos_n = exp_pos;
                  dir_n = exp_dir;
                  if (o_pos == 3'd1 && exp_pos == 3'd0) sweeps_n = o_sweeps + CNT_W'(1);
               end else begin
                  err_n = 1'b1;
               end
            end
            default: state_n = SEARCH;
         endcase
         if (err_n) begin
            pos_n     = o_pos;
            dir_n     = o_dir;
            state_n   = SEARCH;
            err_cnt_n = sat_inc(o_err_count);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= SEARCH;
         o_pos       <= '0;
         o_dir       <= 1'b0;
         o_locked    <= 1'b0;
         o_error     <= 1'b0;
         o_err_count <= '0;
         o_sweeps    <= '0;
      end else begin
         state       <= state_n;
         o_pos       <= pos_n;
         o_dir       <= dir_n;
         o_locked    <= (state_n == TRACK);
         o_error     <= err_n;
         o_err_count <= err_cnt_n;
         o_sweeps    <= sweeps_n;
      end
   end

endmodule

// File: tb/tb_walker_checker.sv
// Directed self-checking bench for walker_checker.
module tb_walker_checker;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_strobe = 1'b0;
   logic [6:0] i_led = '0;
   logic       i_clear = 1'b0;
   logic [2:0] o_pos;
   logic       o_dir, o_locked, o_error;
   logic [7:0] o_err_count, o_sweeps;

   int checks = 0;
   int errors = 0;

   walker_checker #(.CNT_W(8)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_strobe    (i_strobe),
      .i_led       (i_led),
      .i_clear     (i_clear),
      .o_pos       (o_pos),
      .o_dir       (o_dir),
      .o_locked    (o_locked),
      .o_error     (o_error),
      .o_err_count (o_err_count),
      .o_sweeps    (o_sweeps)
   );

   always #5 i_clk = ~i_clk;

   // Drive one cycle of inputs from the falling edge; return 1 time unit after the rising edge.
   task automatic step(input logic stb, input logic [6:0] led, input logic clr);
      @(negedge i_clk);
      i_strobe = stb;
      i_led    = led;
      i_clear  = clr;
      @(posedge i_clk);
      #1;
      i_strobe = 1'b0;
      i_led    = '0;
      i_clear  = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (o_pos !== 3'd0) begin errors++; $display("FAIL rst_pos: got %0d, want 0", o_pos); end
      checks++; if (o_dir !== 1'b0) begin errors++; $display("FAIL rst_dir: got %0b, want 0", o_dir); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b, want 0", o_locked); end
      checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b, want 0", o_error); end
      checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt: got %0d, want 0", o_err_count); end
      checks++; if (o_sweeps !== 8'd0) begin errors++; $display("FAIL rst_sweeps: got %0d, want 0", o_sweeps); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_acquire();
      step(1'b1, 7'b0000001, 1'b0);
      checks++; if (o_locked !== 1'b0 || o_pos !== 3'd0) begin errors++; $display("FAIL acq_first: got locked=%0b pos=%0d, want locked=0 pos=0", o_locked, o_pos); end
      step(1'b1, 7'b0000010, 1'b0);
      checks++; if (o_locked !== 1'b1 || o_pos !== 3'd1) begin errors++; $display("FAIL acq_lock: got locked=%0b pos=%0d, want locked=1 pos=1", o_locked, o_pos); end
      checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL acq_err2: got %0b, want 0", o_error); end
      step(1'b1, 7'b0000100, 1'b0);
      checks++; if (o_pos !== 3'd2 || o_dir !== 1'b0 || o_locked !== 1'b1) begin errors++; $display("FAIL acq_final: got pos=%0d dir=%0b locked=%0b, want pos=2 dir=0 locked=1", o_pos, o_dir, o_locked); end
      checks++; if (o_error !== 1'b0 || o_err_count !== 8'd0) begin errors++; $display("FAIL acq_noerr: got err=%0b cnt=%0d, want 0 0", o_error, o_err_count); end
   endtask

   task automatic test_walk();
      int up_seq[4] = '{3, 4, 5, 6};
      int dn_seq[4] = '{4, 3, 2, 1};
      foreach (up_seq[i]) step(1'b1, 7'd1 << up_seq[i], 1'b0);
      checks++; if (o_pos !== 3'd6 || o_dir !== 1'b0) begin errors++; $display("FAIL walk_top: got pos=%0d dir=%0b, want pos=6 dir=0", o_pos, o_dir); end
      step(1'b1, 7'b0100000, 1'b0);
      checks++; if (o_pos !== 3'd5 || o_dir !== 1'b1) begin errors++; $display("FAIL walk_turn: got pos=%0d dir=%0b, want pos=5 dir=1", o_pos, o_dir); end
      foreach (dn_seq[i]) step(1'b1, 7'd1 << dn_seq[i], 1'b0);
      checks++; if (o_pos !== 3'd1 || o_sweeps !== 8'd0) begin errors++; $display("FAIL walk_pos1: got pos=%0d sweeps=%0d, want pos=1 sweeps=0", o_pos, o_sweeps); end
      step(1'b1, 7'b0000001, 1'b0);
      checks++; if (o_pos !== 3'd0 || o_sweeps !== 8'd1) begin errors++; $display("FAIL walk_sweep: got pos=%0d sweeps=%0d, want pos=0 sweeps=1", o_pos, o_sweeps); end
      checks++; if (o_err_count !== 8'd0 || o_locked !== 1'b1) begin errors++; $display("FAIL walk_clean: got cnt=%0d locked=%0b, want 0 1", o_err_count, o_locked); end
   endtask

   task automatic test_error();
      step(1'b1, 7'b0000010, 1'b0);
      checks++; if (o_pos !== 3'd1 || o_dir !== 1'b0) begin errors++; $display("FAIL bounce_low: got pos=%0d dir=%0b, want pos=1 dir=0", o_pos, o_dir); end
      step(1'b1, 7'b0000100, 1'b0);
      step(1'b1, 7'b0001000, 1'b0);
      step(1'b1, 7'b0001100, 1'b0);
      checks++; if (o_error !== 1'b1 || o_err_count !== 8'd1 || o_locked !== 1'b0) begin errors++; $display("FAIL multi_err: got err=%0b cnt=%0d locked=%0b, want 1 1 0", o_error, o_err_count, o_locked); end
      checks++; if (o_pos !== 3'd3) begin errors++; $display("FAIL err_pos_hold: got %0d, want 3", o_pos); end
      step(1'b0, 7'b0000000, 1'b0);
      checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL err_pulse: got %0b, want 0", o_error); end
      step(1'b1, 7'b0000000, 1'b0);
      checks++; if (o_error !== 1'b0 || o_err_count !== 8'd1) begin errors++; $display("FAIL search_ignore: got err=%0b cnt=%0d, want 0 1", o_error, o_err_count); end
   endtask

   task automatic test_skip_hold();
      step(1'b1, 7'b0000001, 1'b0);
      step(1'b1, 7'b0000010, 1'b0);
      step(1'b1, 7'b0001000, 1'b0);
      checks++; if (o_error !== 1'b1 || o_err_count !== 8'd2 || o_locked !== 1'b0) begin errors++; $display("FAIL skip_err: got err=%0b cnt=%0d locked=%0b, want 1 2 0", o_error, o_err_count, o_locked); end
      step(1'b1, 7'b0000001, 1'b0);
      step(1'b1, 7'b0000000, 1'b0);
      checks++; if (o_error !== 1'b1 || o_err_count !== 8'd3) begin errors++; $display("FAIL acq_invalid: got err=%0b cnt=%0d, want 1 3", o_error, o_err_count); end
      step(1'b1, 7'b0000001, 1'b0);
      step(1'b1, 7'b0000001, 1'b0);
      checks++; if (o_error !== 1'b0 || o_locked !== 1'b0 || o_pos !== 3'd0) begin errors++; $display("FAIL acq_hold: got err=%0b locked=%0b pos=%0d, want 0 0 0", o_error, o_locked, o_pos); end
      step(1'b1, 7'b0000010, 1'b0);
      step(1'b1, 7'b0000010, 1'b0);
      checks++; if (o_error !== 1'b0 || o_locked !== 1'b1 || o_pos !== 3'd1 || o_dir !== 1'b0) begin errors++; $display("FAIL track_hold: got err=%0b locked=%0b pos=%0d dir=%0b, want 0 1 1 0", o_error, o_locked, o_pos, o_dir); end
   endtask

   task automatic test_clear();
      int seq[12] = '{2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};
      for (int k = 0; k < 4; k++) begin
         foreach (seq[i]) step(1'b1, 7'd1 << seq[i], 1'b0);
      end
      checks++; if (o_sweeps !== 8'd5 || o_err_count !== 8'd3) begin errors++; $display("FAIL pre_clear: got sweeps=%0d cnt=%0d, want 5 3", o_sweeps, o_err_count); end
      step(1'b1, 7'b0000001, 1'b1);
      checks++; if (o_sweeps !== 8'd0 || o_err_count !== 8'd0 || o_locked !== 1'b0 || o_error !== 1'b0) begin errors++; $display("FAIL clear: got sweeps=%0d cnt=%0d locked=%0b err=%0b, want 0 0 0 0", o_sweeps, o_err_count, o_locked, o_error); end
      step(1'b1, 7'b0000010, 1'b0);
      checks++; if (o_locked !== 1'b0 || o_pos !== 3'd1 || o_error !== 1'b0) begin errors++; $display("FAIL clear_discard: got locked=%0b pos=%0d err=%0b, want 0 1 0", o_locked, o_pos, o_error); end
   endtask

   task automatic test_saturate_reset();
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 7'b0000001, 1'b0);
         step(1'b1, 7'b0000000, 1'b0);
         if (i == 2) begin
            checks++; if (o_err_count !== 8'd3) begin errors++; $display("FAIL sat_early: got %0d, want 3", o_err_count); end
         end
         if (i == 254) begin
            checks++; if (o_err_count !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d, want 255", o_err_count); end
         end
      end
      checks++; if (o_err_count !== 8'd255 || o_error !== 1'b1) begin errors++; $display("FAIL sat_hold: got cnt=%0d err=%0b, want 255 1", o_err_count, o_error); end
      step(1'b1, 7'b0000001, 1'b0);
      step(1'b1, 7'b0000010, 1'b0);
      step(1'b1, 7'b0000100, 1'b0);
      checks++; if (o_locked !== 1'b1 || o_pos !== 3'd2) begin errors++; $display("FAIL pre_rst_track: got locked=%0b pos=%0d, want 1 2", o_locked, o_pos); end
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      checks++; if (o_pos !== 3'd0 || o_dir !== 1'b0 || o_locked !== 1'b0 || o_error !== 1'b0) begin errors++; $display("FAIL async_rst: got pos=%0d dir=%0b locked=%0b err=%0b, want 0 0 0 0", o_pos, o_dir, o_locked, o_error); end
      checks++; if (o_err_count !== 8'd0 || o_sweeps !== 8'd0) begin errors++; $display("FAIL async_rst_cnt: got cnt=%0d sweeps=%0d, want 0 0", o_err_count, o_sweeps); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      step(1'b1, 7'b0001000, 1'b0);
      checks++; if (o_pos !== 3'd3 || o_locked !== 1'b0 || o_error !== 1'b0) begin errors++; $display("FAIL post_rst_search: got pos=%0d locked=%0b err=%0b, want 3 0 0", o_pos, o_locked, o_error); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_walk();
      test_error();
      test_skip_hold();
      test_clear();
      test_saturate_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
